fifo_uart_tx: RTL and testbench

Serial transmit stage that drains the synchronous byte FIFO and sends each byte as an asynchronous UART frame on a single wire. It sits directly downstream of the FIFO's read port. It issues one-cycle read strobes, captures the FIFO's registered read data, and serializes it LSB-first with start bit, optional even parity bit and stop bit. One read is issued per frame, and the block is the FIFO's only reader.

---
 rtl/fifo_uart_tx.sv | 90 +++++++++
 tb/tb_fifo_uart_tx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a registered-read FIFO and sends each word as an LSB-first UART frame
`timescale 1ns/1ps
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_r_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH) + 1;
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
    state_t                state;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] shift;
    logic                  parity;
    logic                  bit_end;
    logic                  last_bit;
    logic [DATA_WIDTH-1:0] shift_nxt;
    assign bit_end   = cnt == CW'(CLKS_PER_BIT - 1);
    assign last_bit  = idx == IW'(DATA_WIDTH - 1);
    assign shift_nxt = shift >> 1;
    // tx is set on each transition to the level of the state being entered
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state      <= IDLE;
            tx         <= 1'b1;
            fifo_r_en  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            shift      <= '0;
            cnt        <= '0;
            idx        <= '0;
            parity     <= 1'b0;
        end else begin
            fifo_r_en  <= 1'b0;
            frame_done <= 1'b0;
            cnt        <= (bit_end || state inside {IDLE, FETCH, LOAD}) ? '0 : cnt + CW'(1);
            case (state)
                IDLE: if (tx_en && !fifo_empty) begin
                    state     <= FETCH;
                    fifo_r_en <= 1'b1;
                    busy      <= 1'b1;
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    shift  <= fifo_data;
                    parity <= ^fifo_data;
                    tx     <= 1'b0;
                    state  <= START;
                end
                START: if (bit_end) begin
                    idx   <= '0;
                    tx    <= shift[0];
                    state <= DATA;
                end
                DATA: if (bit_end) begin
                    shift <= shift_nxt;
                    idx   <= idx + IW'(1);
                    tx    <= last_bit ? ((PARITY_EN != 0) ? parity : 1'b1) : shift_nxt[0];
                    if (last_bit) state <= (PARITY_EN != 0) ? PARITY : STOP;
                end
                PARITY: if (bit_end) begin
                    tx    <= 1'b1;
                    state <= STOP;
                end
                STOP: begin
                    frame_done <= cnt == CW'(CLKS_PER_BIT - 2);
                    if (bit_end) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed-random bench; dut 0 without parity, dut 1 with even parity
`timescale 1ns/1ps
module tb_fifo_uart_tx;
    localparam int CPB = 4;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en[2];
    logic       empty[2];
    logic       r_en[2];
    logic       tx[2];
    logic       busy[2];
    logic       fd[2];
    logic [7:0] fdata[2];
    logic [7:0] mem[2][64];
    logic       prev_r[2];
    int         wp[2], rp[2], rcount[2], lowcnt[2], dbl[2];
    int         npass = 0, nfail = 0;
    int         w, rc, r1, l1;
    logic [7:0] rb;

    always #5 clk = ~clk;
    assign empty[0] = wp[0] == rp[0];
    assign empty[1] = wp[1] == rp[1];

    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) u0 (
        .clk(clk), .reset(reset), .tx_en(en[0]), .fifo_empty(empty[0]), .fifo_data(fdata[0]),
        .fifo_r_en(r_en[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(fd[0]));
    fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) u1 (
        .clk(clk), .reset(reset), .tx_en(en[1]), .fifo_empty(empty[1]), .fifo_data(fdata[1]),
        .fifo_r_en(r_en[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(fd[1]));

    // registered-read FIFO models
    always @(posedge clk)
        for (int d = 0; d < 2; d++)
            if (r_en[d] && wp[d] != rp[d]) begin
                fdata[d] <= mem[d][rp[d] % 64];
                rp[d]    <= rp[d] + 1;
            end

    always @(negedge clk)
        for (int d = 0; d < 2; d++) begin
            rcount[d] <= rcount[d] + int'(r_en[d]);
            lowcnt[d] <= lowcnt[d] + int'(!tx[d]);
            dbl[d]    <= dbl[d] + int'(r_en[d] && prev_r[d]);
            prev_r[d] <= r_en[d];
        end

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int d, input logic [7:0] b);
        mem[d][wp[d] % 64] = b;
        wp[d] = wp[d] + 1;
    endtask

    // expected line built from frame rules: start, data LSB first, optional parity, stop
    task automatic frame(input int d, input logic [7:0] b, input int drop, output int waited);
        logic [11:0] bits;
        logic [47:0] otx, ofd, obz, etx, efd, ebz;
        int nb, len;
        nb = 10 + d;
        len = nb * CPB;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        if (d == 1) bits[9] = ^b;
        otx = '0; ofd = '0; obz = '0; etx = '0; efd = '0; ebz = '0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!r_en[d] && waited < 60);
        chk({r_en[d], tx[d], busy[d]}, 3'b111, $sformatf("fetch d%0d %h", d, b));
        if (!r_en[d]) return;
        @(negedge clk);
        chk({r_en[d], tx[d], busy[d]}, 3'b011, $sformatf("load d%0d %h", d, b));
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == drop) en[d] = 1'b0;
            otx[i] = tx[d];
            ofd[i] = fd[d];
            obz[i] = busy[d];
            etx[i] = bits[i / CPB];
            efd[i] = i == len - 1;
            ebz[i] = 1'b1;
        end
        chk(otx, etx, $sformatf("tx wave d%0d %h", d, b));
        chk(ofd, efd, $sformatf("frame_done d%0d %h", d, b));
        chk(obz, ebz, $sformatf("busy d%0d %h", d, b));
        @(negedge clk);
        chk({tx[d], busy[d], fd[d], r_en[d]}, 4'b1000, $sformatf("idle after d%0d %h", d, b));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        en[0] = 1'b1;
        en[1] = 1'b1;
        push(0, 8'hA5);
        push(1, 8'h07);
        push(1, 8'h03);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk({tx[0], r_en[0], busy[0], fd[0]}, 4'b1000, "reset d0");
            chk({tx[1], r_en[1], busy[1], fd[1]}, 4'b1000, "reset d1");
        end
        en[1] = 1'b0;
        reset = 1'b1;
        r1 = rcount[1];
        l1 = lowcnt[1];
        frame(0, 8'hA5, -1, w);
        chk(w, 1, "read latency after release");
        repeat (5) @(negedge clk);
        chk(rcount[0], 1, "single read A5");
        chk(rcount[1] - r1, 0, "gated reads d1");
        chk(lowcnt[1] - l1, 0, "gated line d1");
        en[1] = 1'b1;
        frame(1, 8'h07, -1, w);
        frame(1, 8'h03, -1, w);
        chk(w, 1, "parity back-to-back gap");
        rc = rcount[0];
        push(0, 8'h11);
        push(0, 8'h22);
        push(0, 8'h33);
        frame(0, 8'h11, -1, w);
        frame(0, 8'h22, -1, w);
        chk(w, 1, "gap 11-22");
        frame(0, 8'h33, -1, w);
        chk(w, 1, "gap 22-33");
        repeat (10) @(negedge clk);
        chk(rcount[0] - rc, 3, "three reads");
        chk({tx[0], busy[0]}, 2'b10, "idle when empty");
        for (int k = 0; k < 3; k++) begin
            rb = 8'($urandom);
            push(k % 2, rb);
            frame(k % 2, rb, -1, w);
        end
        rc = rcount[0];
        push(0, 8'h44);
        push(0, 8'h55);
        frame(0, 8'h44, 20, w);
        repeat (20) @(negedge clk);
        chk(rcount[0] - rc, 1, "no read after tx_en drop");
        chk({tx[0], busy[0]}, 2'b10, "line idle after drop");
        en[0] = 1'b1;
        frame(0, 8'h55, -1, w);
        rc = rcount[0];
        push(0, 8'h5A);
        push(0, 8'h6B);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!r_en[0] && w < 60);
        chk(r_en[0], 1, "fetch 5A");
        repeat (18) @(negedge clk);
        chk({tx[0], busy[0]}, 2'b11, "data bit 3 of 5A");
        #2 reset = 1'b0;
        #1 chk({tx[0], busy[0], r_en[0]}, 3'b100, "async reset mid-frame");
        repeat (2) @(negedge clk);
        chk({tx[0], busy[0]}, 2'b10, "held in reset");
        reset = 1'b1;
        frame(0, 8'h6B, -1, w);
        repeat (5) @(negedge clk);
        chk(rcount[0] - rc, 2, "5A not re-read");
        chk(dbl[0] + dbl[1], 0, "no consecutive read strobes");
        $display("%0d/%0d checks passed", npass, npass + nfail);
        $finish;
    end
endmodule
